// File: rtl/fifo_rr_drain.sv
// fifo_rr_drain: round-robin, burst-limited drain of FWFT source FIFOs into one registered valid/ready stream
module fifo_rr_drain #(
  parameter int NUM_SRC   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_empty,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  output logic [NUM_SRC-1:0]         src_pop,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_SRC)-1:0] out_src,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic                       busy
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int BW = $clog2(MAX_BURST + 1);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_src;
  logic [SW-1:0]    r_owner;
  logic [BW-1:0]    r_burst;
  logic [WIDTH-1:0] w_heads [NUM_SRC];
  logic [SW-1:0]    w_idx;
  logic [SW-1:0]    w_rot;
  logic [SW-1:0]    w_sel;
  logic             w_load;
  logic             w_any;
  logic             w_stay;
  logic             w_pop;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_head
    assign w_heads[g] = src_data[g*WIDTH +: WIDTH];
  end
  assign w_load    = !r_valid || out_ready;
  assign w_any     = ~&src_empty;
  assign w_stay    = !src_empty[r_owner] && (r_burst < BW'(MAX_BURST));
  assign w_sel     = w_stay ? r_owner : w_rot;
  assign w_pop     = rst_n && w_load && w_any && !flush;
  assign src_pop   = w_pop ? (NUM_SRC'(1) << w_sel) : '0;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign busy      = r_valid || w_any;
  // Rotation target: first non-empty source after the owner, owner itself checked last
  always_comb begin
    w_rot = r_owner;
    w_idx = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      w_idx = SW'((int'(r_owner) + k) % NUM_SRC);
      if (!src_empty[w_idx]) w_rot = w_idx;
    end
  end
  // Output register and burst/owner bookkeeping; a rotation restarts the burst at 1 even onto the same source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_owner <= '0;
      r_burst <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_owner <= '0;
      r_burst <= '0;
    end else if (w_load) begin
      r_valid <= w_pop;
      if (w_pop) begin
        r_data  <= w_heads[w_sel];
        r_src   <= w_sel;
        r_owner <= w_stay ? r_owner : w_sel;
        r_burst <= w_stay ? r_burst + 1'b1 : BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fifo_rr_drain.sv
// tb_fifo_rr_drain: queue-modelled source FIFOs, directed traffic, scoreboard monitor on the output stream
module tb_fifo_rr_drain;
  localparam int N = 4;
  localparam int W = 32;
  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   src_empty;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_pop;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_ready = 1'b0;
  logic           flush = 1'b0;
  logic           busy;
  logic [W-1:0]   q [N][$];
  logic [33:0]    exp_q [$];
  logic [N-1:0]   pop_snap = '0;
  int             checks = 0;
  int             errors = 0;

  fifo_rr_drain #(.NUM_SRC(N), .WIDTH(W), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .src_empty(src_empty), .src_data(src_data),
    .src_pop(src_pop), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic void refresh();
    for (int i = 0; i < N; i++) begin
      src_empty[i] = (q[i].size() == 0);
      src_data[i*W +: W] = src_empty[i] ? '0 : q[i][0];
    end
  endfunction

  // Source FIFO model: pop strobes seen before the edge take effect just after it
  always @(negedge clk) pop_snap = src_pop;
  always @(posedge clk) begin
    #1;
    if (rst_n)
      for (int i = 0; i < N; i++)
        if (pop_snap[i] && q[i].size() > 0) void'(q[i].pop_front());
    refresh();
  end

  // Monitor: legality of pops and in-order scoreboard comparison of every accepted output
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n) begin
      if (src_pop != '0) chk("pop_legal", {62'b0, $onehot(src_pop), ~|(src_pop & src_empty)}, 64'h3);
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got src=%0d data=%0h want none", out_src, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_src", 64'(out_src), 64'(e[33:32]));
          chk("out_data", 64'(out_data), 64'(e[31:0]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int s, input logic [W-1:0] d);
    q[s].push_back(d);
    refresh();
  endtask

  task automatic expect_out(input int s, input logic [W-1:0] d);
    exp_q.push_back({2'(s), d});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      step();
      n++;
    end
    chk({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    refresh();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_src", 64'(out_src), 64'd0);
    chk("rst_pop", 64'(src_pop), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    // single source, latency of one cycle from pop to out_valid
    for (int i = 0; i < 3; i++) begin
      load(2, 32'hA1 + i);
      expect_out(2, 32'hA1 + i);
    end
    @(negedge clk);
    chk("t1_pop0", 64'(src_pop), 64'b0100);
    chk("t1_valid0", 64'(out_valid), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_valid1", 64'(out_valid), 64'd1);
    chk("t1_src1", 64'(out_src), 64'd2);
    chk("t1_pop1", 64'(src_pop), 64'b0100);
    drain("t1");
    do_flush();
    // burst limit forces rotation after four pops from src0
    for (int i = 0; i < 6; i++) load(0, 32'h10 + i);
    for (int i = 0; i < 2; i++) load(1, 32'h20 + i);
    for (int i = 0; i < 4; i++) expect_out(0, 32'h10 + i);
    for (int i = 0; i < 2; i++) expect_out(1, 32'h20 + i);
    for (int i = 4; i < 6; i++) expect_out(0, 32'h10 + i);
    drain("t2");
    do_flush();
    // lone source keeps streaming after its burst expires, no bubbles
    for (int i = 0; i < 6; i++) begin
      load(3, 32'h30 + i);
      expect_out(3, 32'h30 + i);
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_no_bubble", 64'(out_valid), 64'd1);
    end
    drain("t3");
    do_flush();
    // backpressure holds the output register and blocks pops
    out_ready = 1'b0;
    load(0, 32'h40);
    load(0, 32'h41);
    expect_out(0, 32'h40);
    expect_out(0, 32'h41);
    @(negedge clk);
    chk("t4_first_pop", 64'(src_pop), 64'b0001);
    @(negedge clk);
    chk("t4_valid", 64'(out_valid), 64'd1);
    chk("t4_nopop0", 64'(src_pop), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t4_nopop", 64'(src_pop), 64'd0);
      chk("t4_hold_data", 64'(out_data), 64'h40);
      chk("t4_hold_src", 64'(out_src), 64'd0);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_pop", 64'(src_pop), 64'b0001);
    @(negedge clk);
    chk("t4_next_data", 64'(out_data), 64'h41);
    drain("t4");
    do_flush();
    // flush drops the held entry and restarts arbitration at src0
    for (int i = 0; i < 3; i++) load(1, 32'h51 + i);
    expect_out(1, 32'h51);
    step();
    step();
    flush = 1'b1;
    load(0, 32'hC0);
    expect_out(0, 32'hC0);
    expect_out(1, 32'h53);
    @(negedge clk);
    chk("t5_flush_nopop", 64'(src_pop), 64'd0);
    chk("t5_flush_valid", 64'(out_valid), 64'd1);
    step();
    flush = 1'b0;
    chk("t5_after_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("t5_restart_src0", 64'(src_pop), 64'b0001);
    drain("t5");
    do_flush();
    // asynchronous reset mid-burst on src1
    for (int i = 0; i < 4; i++) load(1, 32'h60 + i);
    expect_out(1, 32'h60);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_pop", 64'(src_pop), 64'd0);
    chk("t6_data", 64'(out_data), 64'd0);
    chk("t6_src", 64'(out_src), 64'd0);
    for (int i = 0; i < N; i++) q[i].delete();
    exp_q.delete();
    refresh();
    step();
    step();
    rst_n = 1'b1;
    load(1, 32'h71);
    load(0, 32'h70);
    expect_out(0, 32'h70);
    expect_out(1, 32'h71);
    drain("t6");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
